// File: rtl/rv32i_types.sv
// Shared types for the instruction fetch path: word type, fetch FSM states,
// and the canonical NOP encoding (addi x0, x0, 0).
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RESP     = 2'd2
    } fetch_state_e;

    localparam rv32i_word NOP_ENC = 32'h0000_0013;

endpackage

// File: rtl/fetch_line_reg.sv
// Single-entry instruction line buffer: one address/data pair plus a valid bit.
// Invalidate beats load on the valid bit so a flush racing a refill leaves it empty.
module fetch_line_reg
    import rv32i_types::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      inval,
    input  rv32i_word load_addr,
    input  rv32i_word load_data,
    output logic      line_valid,
    output rv32i_word line_addr,
    output rv32i_word line_data
);

    logic      line_valid_q, line_valid_d;
    rv32i_word line_addr_q, line_addr_d;
    rv32i_word line_data_q, line_data_d;

    always_comb begin
        line_valid_d = line_valid_q;
        line_addr_d  = line_addr_q;
        line_data_d  = line_data_q;
        if (load) begin
            line_valid_d = 1'b1;
            line_addr_d  = load_addr;
            line_data_d  = load_data;
        end
        if (inval) begin
            line_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid_q <= 1'b0;
        end else begin
            line_valid_q <= line_valid_d;
        end
    end

    // Address/data are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        line_addr_q <= line_addr_d;
        line_data_q <= line_data_d;
    end

    assign line_valid = line_valid_q;
    assign line_addr  = line_addr_q;
    assign line_data  = line_data_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch front end: single-line buffer in front of instruction memory,
// misaligned-pc trap to NOP, and saturating hit/miss counters.
module imem_fetch
    import rv32i_types::*;
#(
    parameter rv32i_word NOP_INSTR = NOP_ENC,
    parameter int        CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  rv32i_word        pc,
    input  logic             imem_read,
    output logic             imem_resp,
    output rv32i_word        instr,
    input  logic             flush,
    output rv32i_word        mem_addr,
    output logic             mem_read,
    input  rv32i_word        mem_rdata,
    input  logic             mem_resp,
    output logic             misaligned,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    fetch_state_e     state_q, state_d;
    rv32i_word        req_addr_q, req_addr_d;
    logic             imem_resp_q, imem_resp_d;
    rv32i_word        instr_q, instr_d;
    rv32i_word        mem_addr_q, mem_addr_d;
    logic             mem_read_q, mem_read_d;
    logic             misaligned_q, misaligned_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic      line_load;
    logic      line_valid;
    rv32i_word line_addr;
    rv32i_word line_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    fetch_line_reg u_line (
        .clk        (clk),
        .rst        (rst),
        .load       (line_load),
        .inval      (flush),
        .load_addr  (req_addr_q),
        .load_data  (mem_rdata),
        .line_valid (line_valid),
        .line_addr  (line_addr),
        .line_data  (line_data)
    );

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        imem_resp_d  = 1'b0;
        instr_d      = instr_q;
        mem_addr_d   = mem_addr_q;
        mem_read_d   = 1'b0;
        misaligned_d = 1'b0;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        line_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (imem_read) begin
                    req_addr_d = pc;
                    if (pc[1:0] != 2'b00) begin
                        state_d      = RESP;
                        imem_resp_d  = 1'b1;
                        misaligned_d = 1'b1;
                        instr_d      = NOP_INSTR;
                    // A flush in the accepting cycle must not let the stale line hit.
                    end else if (line_valid && !flush && (pc == line_addr)) begin
                        state_d     = RESP;
                        imem_resp_d = 1'b1;
                        instr_d     = line_data;
                        hit_cnt_d   = sat_inc(hit_cnt_q);
                    end else begin
                        state_d    = MEM_WAIT;
                        mem_read_d = 1'b1;
                        mem_addr_d = pc;
                        miss_cnt_d = sat_inc(miss_cnt_q);
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_resp) begin
                    state_d     = RESP;
                    line_load   = 1'b1;
                    imem_resp_d = 1'b1;
                    instr_d     = mem_rdata;
                end else begin
                    mem_read_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            imem_resp_q  <= 1'b0;
            instr_q      <= '0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            misaligned_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            imem_resp_q  <= imem_resp_d;
            instr_q      <= instr_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            misaligned_q <= misaligned_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign imem_resp  = imem_resp_q;
    assign instr      = instr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_read   = mem_read_q;
    assign misaligned = misaligned_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: the driver queues expected responses,
// a negedge monitor pops and compares them whenever imem_resp is high.
module tb_imem_fetch;

    localparam int KIND_HIT = 0;
    localparam int KIND_MISS = 1;
    localparam int KIND_MIS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        imem_read = 1'b0;
    logic        imem_resp;
    logic [31:0] instr;
    logic        flush = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        misaligned;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    logic [31:0] pc2 = '0;
    logic        imem_read2 = 1'b0;
    logic        imem_resp2;
    logic [31:0] instr2;
    logic        flush2 = 1'b0;
    logic [31:0] mem_addr2;
    logic        mem_read2;
    logic [31:0] mem_rdata2 = '0;
    logic        mem_resp2 = 1'b0;
    logic        misaligned2;
    logic [3:0]  hit_cnt2;
    logic [3:0]  miss_cnt2;

    typedef struct {
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    imem_fetch #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pc(pc), .imem_read(imem_read), .imem_resp(imem_resp),
        .instr(instr), .flush(flush), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .misaligned(misaligned),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    imem_fetch #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .pc(pc2), .imem_read(imem_read2), .imem_resp(imem_resp2),
        .instr(instr2), .flush(flush2), .mem_addr(mem_addr2), .mem_read(mem_read2),
        .mem_rdata(mem_rdata2), .mem_resp(mem_resp2), .misaligned(misaligned2),
        .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!done && imem_resp === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got instr %0h, expected no response", instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_instr", 64'(instr), 64'(e.instr));
                check("resp_misaligned", 64'(misaligned), 64'(e.mis));
            end
        end
    end

    // Entered and left just after a rising edge with the DUT in IDLE.
    task automatic fetch(input logic [31:0] a, input int kind, input int delay,
                         input logic [31:0] rdata, input logic [31:0] exp_instr,
                         input bit fl_acc, input bit fl_resp);
        exp_t e;
        e.instr = exp_instr;
        e.mis   = (kind == KIND_MIS);
        exp_q.push_back(e);
        pc = a;
        imem_read = 1'b1;
        flush = fl_acc;
        @(posedge clk); #1;
        imem_read = 1'b0;
        flush = 1'b0;
        if (kind == KIND_MISS) begin
            for (int i = 0; i < delay; i++) begin
                check("mem_read_held", 64'(mem_read), 64'(1));
                check("mem_addr", 64'(mem_addr), 64'(a));
                check("no_early_resp", 64'(imem_resp), 64'(0));
                if (i == delay - 1) begin
                    mem_resp = 1'b1;
                    mem_rdata = rdata;
                    flush = fl_resp;
                end
                @(posedge clk); #1;
                mem_resp = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
                flush = 1'b0;
            end
        end else begin
            check("no_mem_read", 64'(mem_read), 64'(0));
        end
        check("resp_latency", 64'(imem_resp), 64'(1));
        check("mem_read_in_resp", 64'(mem_read), 64'(0));
        @(posedge clk); #1;
        check("resp_single_pulse", 64'(imem_resp), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_resp", 64'(imem_resp), 64'(0));
        check("rst_mem_read", 64'(mem_read), 64'(0));
        check("rst_instr", 64'(instr), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_misaligned", 64'(misaligned), 64'(0));
        check("rst_hit_cnt", 64'(hit_cnt), 64'(0));
        check("rst_miss_cnt", 64'(miss_cnt), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold miss, 3-cycle memory
        fetch(32'h0000_0010, KIND_MISS, 3, 32'h00F0_0093, 32'h00F0_0093, 1'b0, 1'b0);
        check("cold_miss_cnt", 64'(miss_cnt), 64'(1));
        check("cold_hit_cnt", 64'(hit_cnt), 64'(0));

        // Repeat fetch hits
        fetch(32'h0000_0010, KIND_HIT, 0, 32'h0, 32'h00F0_0093, 1'b0, 1'b0);
        check("hit_cnt_1", 64'(hit_cnt), 64'(1));

        // Flush while idle, refetch misses
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        fetch(32'h0000_0010, KIND_MISS, 2, 32'h00F0_0093, 32'h00F0_0093, 1'b0, 1'b0);
        check("flush_miss_cnt", 64'(miss_cnt), 64'(2));

        // Misaligned pc returns NOP without memory access
        fetch(32'h0000_0012, KIND_MIS, 0, 32'h0, 32'h0000_0013, 1'b0, 1'b0);
        check("mis_hit_cnt", 64'(hit_cnt), 64'(1));
        check("mis_miss_cnt", 64'(miss_cnt), 64'(2));

        // Flush coincident with mem_resp: data delivered, line left invalid
        fetch(32'h0000_0020, KIND_MISS, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1);
        fetch(32'h0000_0020, KIND_MISS, 1, 32'h1111_2222, 32'h1111_2222, 1'b0, 1'b0);
        check("flush_resp_miss_cnt", 64'(miss_cnt), 64'(4));

        // Flush coincident with acceptance forces a miss
        fetch(32'h0000_0020, KIND_MISS, 1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
        check("flush_acc_miss_cnt", 64'(miss_cnt), 64'(5));
        check("flush_acc_hit_cnt", 64'(hit_cnt), 64'(1));

        // Held imem_read: back-to-back hits, one response every 2 cycles
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.instr = 32'h1234_5678;
            e.mis = 1'b0;
            exp_q.push_back(e);
        end
        pc = 32'h0000_0020;
        imem_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 4) imem_read = 1'b0;
            check("b2b_resp_pattern", 64'(imem_resp), 64'((i % 2) == 0));
            check("b2b_no_mem_read", 64'(mem_read), 64'(0));
        end
        check("b2b_hit_cnt", 64'(hit_cnt), 64'(4));

        // Stray mem_resp while idle is ignored
        mem_resp = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        check("stray_no_resp", 64'(imem_resp), 64'(0));
        check("stray_instr_hold", 64'(instr), 64'(32'h1234_5678));
        fetch(32'h0000_0020, KIND_HIT, 0, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
        check("stray_hit_cnt", 64'(hit_cnt), 64'(5));

        // Reset in MEM_WAIT abandons the fetch
        pc = 32'h0000_0030;
        imem_read = 1'b1;
        @(posedge clk); #1;
        imem_read = 1'b0;
        check("pre_rst_mem_read", 64'(mem_read), 64'(1));
        rst = 1'b1;
        mem_resp = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        flush = 1'b1;
        imem_read = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        flush = 1'b0;
        imem_read = 1'b0;
        mem_resp = 1'b1;
        mem_rdata = 32'hCAFE_0002;
        check("midrst_mem_read", 64'(mem_read), 64'(0));
        check("midrst_instr", 64'(instr), 64'(0));
        check("midrst_mem_addr", 64'(mem_addr), 64'(0));
        check("midrst_misaligned", 64'(misaligned), 64'(0));
        check("midrst_hit_cnt", 64'(hit_cnt), 64'(0));
        check("midrst_miss_cnt", 64'(miss_cnt), 64'(0));
        @(posedge clk); #1;
        mem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("midrst_no_resp", 64'(imem_resp), 64'(0));
            check("midrst_no_mem_read", 64'(mem_read), 64'(0));
            check("midrst_instr_zero", 64'(instr), 64'(0));
            @(posedge clk); #1;
        end
        // Line must be empty after reset, so the old 0x20 entry misses
        fetch(32'h0000_0020, KIND_MISS, 1, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 1'b0);
        check("post_rst_miss_cnt", 64'(miss_cnt), 64'(1));
        check("post_rst_hit_cnt", 64'(hit_cnt), 64'(0));

        // 4-bit counters: one miss then ~21 held hits must stick at 0xF
        pc2 = 32'h0000_0040;
        imem_read2 = 1'b1;
        @(posedge clk); #1;
        mem_resp2 = 1'b1;
        mem_rdata2 = 32'h0000_0093;
        @(posedge clk); #1;
        mem_resp2 = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        imem_read2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sat_hit_cnt", 64'(hit_cnt2), 64'(4'hF));
        check("sat_miss_cnt", 64'(miss_cnt2), 64'(1));
        check("sat_instr", 64'(instr2), 64'(32'h0000_0093));

        @(negedge clk);
        done = 1'b1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0013, the instruction returned for a misaligned pc.
REQ-002 SHALL have parameter CNT_W, default 16, the performance counter width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc  input  32  CPU fetch address.
REQ-006 imem_read  input  1  CPU fetch request.
REQ-007 imem_resp  output  1  one-cycle pulse; instr is valid in that cycle.
REQ-008 instr  output  32  fetched instruction; holds its last value between responses.
REQ-009 flush  input  1  invalidates the held line (fence.i, or a store to instruction space).
REQ-010 mem_addr  output  32  instruction memory address.
REQ-011 mem_read  output  1  memory read request; held until mem_resp.
REQ-012 mem_rdata  input  32  memory read data; valid when mem_resp=1.
REQ-013 mem_resp  input  1  memory read completion.
REQ-014 misaligned  output  1  asserted with imem_resp when pc[1:0]!=0.
REQ-015 hit_cnt, miss_cnt  output  CNT_W each  saturating performance counters.

Function
REQ-016 The FSM SHALL have three states: IDLE, MEM_WAIT and RESP.
REQ-017 In IDLE with imem_read=1, the block SHALL accept the request and capture pc into req_addr; requests arriving in any other state SHALL be ignored.
REQ-018 An accepted request with pc[1:0]!=0 SHALL go to RESP and return NOP_INSTR with misaligned=1, without any memory access.
REQ-019 An accepted request that hits (line_valid=1 and pc==line_addr) SHALL go to RESP and increment hit_cnt.
REQ-020 An accepted request that misses SHALL go to MEM_WAIT and increment miss_cnt.
REQ-021 In MEM_WAIT, mem_read SHALL be 1 and mem_addr SHALL equal req_addr, both stable until mem_resp.
REQ-022 On mem_resp in MEM_WAIT, the block SHALL load line_addr=req_addr and line_data=mem_rdata, set line_valid=1, and go to RESP.
REQ-023 In RESP, imem_resp SHALL be 1 and instr SHALL equal the line data (or NOP_INSTR), and the next state SHALL be IDLE.
REQ-024 Latency from request acceptance SHALL be: hit or misaligned, imem_resp one cycle later; miss, imem_resp one cycle after the mem_resp cycle.
REQ-025 A CPU that still holds imem_read in RESP SHALL have that request accepted in the following IDLE cycle, so back-to-back hits give one response every 2 cycles.
REQ-026 flush SHALL clear line_valid in every state; flush in the same cycle as mem_resp SHALL still deliver the fetched data, but line_valid SHALL end at 0.
REQ-027 flush in the same cycle as an IDLE acceptance SHALL treat that request as a miss.
REQ-028 mem_resp arriving outside MEM_WAIT SHALL be ignored.
REQ-029 Counters SHALL saturate at all-ones and never wrap.
REQ-030 mem_read SHALL be 0 in every state other than MEM_WAIT.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL set state=IDLE, imem_resp=0, mem_read=0, instr=0, mem_addr=0, misaligned=0, line_valid=0, hit_cnt=0 and miss_cnt=0.
REQ-032 rst during MEM_WAIT SHALL abandon the fetch: mem_read is 0 from the next cycle, and any later mem_resp is ignored.
REQ-033 rst SHALL take priority over imem_read, flush and mem_resp in the same cycle.

Structure
REQ-034 rv32i_types SHALL hold rv32i_word, the fetch-state enum (IDLE, MEM_WAIT, RESP) and the NOP encoding constant.
REQ-035 The single-entry line buffer (addr/data/valid, with load and invalidate) SHALL be the sub-module fetch_line_reg; all other logic SHALL be flat.

Verification
REQ-036 Cold miss: pc=0x0000_0010, memory responds 3 cycles later with 0x00F0_0093 -> mem_read held for 3 cycles at mem_addr=0x10; imem_resp pulses once with instr=0x00F0_0093; miss_cnt=1.
REQ-037 Repeat fetch of pc=0x10 -> imem_resp one cycle after acceptance, mem_read stays 0, hit_cnt=1.
REQ-038 flush, then fetch pc=0x10 -> miss, memory accessed again, miss_cnt=2.
REQ-039 pc=0x0000_0012 -> imem_resp with instr=0x0000_0013 and misaligned=1, no mem_read, counters unchanged.
REQ-040 rst asserted mid MEM_WAIT, then a stray mem_resp -> no imem_resp, line_valid=0, all outputs at reset values.
REQ-041 Counter saturation: force 70000 hits with CNT_W=16 -> hit_cnt=0xFFFF.
